// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - Opcode encodings presented on the 3-bit op input.
//   - FSM state encoding for alu_seq.
//   - Bit positions of the status flags inside the packed flag register.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial
// product per clock, multiplier bits consumed LSB first.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load a/b and begin (ignored while busy)
//   a, b         multiplicand / multiplier (WIDTH bits)
//   busy         an operation is in progress
//   done         high during the cycle in which the final step executes
//   product      2*WIDTH-bit product; valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Upper half accumulates partial sums; lower half starts as the
  // multiplier and is shifted out one bit per step.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step    = {partial, acc_q[WIDTH-1:1]};

    count_d = count_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (count_q != '0) begin
      acc_d   = step;
      count_d = count_q - CW'(1);
    end else if (start) begin
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
      count_d = CW'(WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign busy    = (count_q != '0);
  // The product is offered combinationally alongside done so the consumer
  // can register it on the same edge as the last step, saving a cycle.
  assign done    = (count_q == CW'(1));
  assign product = step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   op, data1, data2     opcode and operands
//   out_valid/out_ready  result handshake
//   result, result_hi    result (MUL: low half) and MUL high half
//   flag_z/c/v/n         zero, carry/borrow, overflow, negative
// Single-cycle ops complete one cycle after accept; MUL runs through the
// iterative engine and completes WIDTH+1 cycles after accept.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int SHW = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  logic [SHW-1:0]       sh;
  logic [WIDTH:0]       sum_w, diff_w, shl_w, shr_w;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (data1),
    .b       (data2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath. The extra bit on each intermediate captures
  // carry-out, borrow, or the bit shifted across the word boundary.
  always_comb begin
    sh     = data2[SHW-1:0];
    sum_w  = {1'b0, data1} + {1'b0, data2};
    diff_w = {1'b0, data1} - {1'b0, data2};
    shl_w  = {1'b0, data1} << sh;
    shr_w  = {data1, 1'b0} >> sh;

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (data1[WIDTH-1] == data2[WIDTH-1])
               && (sum_w[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (data1[WIDTH-1] != data2[WIDTH-1])
               && (diff_w[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND: alu_res = data1 & data2;
      OP_OR:  alu_res = data1 | data2;
      OP_XOR: alu_res = data1 ^ data2;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d = ST_BUSY;
          end else begin
            state_d          = ST_DONE;
            out_valid_d      = 1'b1;
            result_d         = alu_res;
            result_hi_d      = '0;
            flags_d[FLAG_Z]  = (alu_res == '0);
            flags_d[FLAG_C]  = alu_c;
            flags_d[FLAG_V]  = alu_v;
            flags_d[FLAG_N]  = alu_res[WIDTH-1];
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d          = ST_DONE;
          out_valid_d      = 1'b1;
          result_d         = mul_product[WIDTH-1:0];
          result_hi_d      = mul_product[2*WIDTH-1:WIDTH];
          flags_d[FLAG_Z]  = (mul_product == '0);
          flags_d[FLAG_C]  = |mul_product[2*WIDTH-1:WIDTH];
          flags_d[FLAG_V]  = 1'b0;
          flags_d[FLAG_N]  = mul_product[WIDTH-1];
        end else if (!mul_busy) begin
          // Engine idle without signalling done: recover rather than hang.
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_n    = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard testbench for alu_seq: the driver pushes the expected response
// from an arithmetic reference model; a monitor pops and compares whenever
// the DUT completes an output handshake.
module tb_alu_seq;

  localparam int     W    = 8;
  localparam longint M    = (longint'(1) << W) - 1;
  localparam longint SMAX = (longint'(1) << (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W-1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] data1, data2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, result_hi;
  logic         flag_z, flag_c, flag_v, flag_n;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data1(data1), .data2(data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hold     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    longint     a, b, r, hi;
    bit         z, c, v, n;
    int         lat;
    int         acc;
  } exp_t;

  exp_t scb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x > SMAX) ? x - (M + 1) : x;
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] o, input longint a, input longint b);
    exp_t   e;
    longint s, sh, p;
    e.op = o; e.a = a; e.b = b; e.hi = 0; e.c = 0; e.v = 0;
    sh = b % W;
    case (o)
      3'd0: begin s = a + b; e.r = s & M; e.c = (s > M);
                  s = sgn(a) + sgn(b); e.v = (s > SMAX) || (s < SMIN); end
      3'd1: begin s = a - b; e.r = s & M; e.c = (a < b);
                  s = sgn(a) - sgn(b); e.v = (s > SMAX) || (s < SMIN); end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: begin e.r = (a << sh) & M; e.c = (sh != 0) && (((a >> (W - sh)) & 1) == 1); end
      3'd6: begin e.r = a >> sh; e.c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      default: begin p = a * b; e.r = p & M; e.hi = p >> W; e.c = (e.hi != 0); end
    endcase
    e.z   = (e.r == 0) && (e.hi == 0);
    e.n   = ((e.r >> (W-1)) & 1) == 1;
    e.lat = (o == 3'd7) ? W + 1 : 1;
    e.acc = 0;
    return e;
  endfunction

  // Called at posedge+1 with the DUT idle and the scoreboard empty.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   t;
    e = model(o, longint'(a), longint'(b));
    in_valid = 1'b1; op = o; data1 = a; data2 = b;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.acc = cyc;
    scb.push_back(e);
    // Random in_valid pulses with junk operands until the result drains;
    // the DUT must ignore them.
    t = 0;
    while (scb.size() != 0 && t < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 3'($urandom); data1 = W'($urandom); data2 = W'($urandom);
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (scb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=pending required=empty");
      scb.delete();
    end
    $display("txn op=%0d a=%02h b=%02h -> r=%02h hi=%02h", o, a, b, e.r[W-1:0], e.hi[W-1:0]);
  endtask

  // out_ready: random, or held low while hold counts down.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin out_ready = 1'b0; hold--; end
      else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor.
  initial begin
    bit           prev_ov = 0, prev_rdy = 0, expect_ready = 0;
    logic [W-1:0] s_r, s_hi;
    logic [3:0]   s_f;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_ov = 0; expect_ready = 0; continue; end
      if (expect_ready) begin chk("in_ready_after_handshake", in_ready, 1); expect_ready = 0; end
      if (scb.size() > 0) chk("in_ready_low_inflight", in_ready, 0);
      if (out_valid && !prev_ov) begin
        if (scb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0");
        end else chk("latency", cyc - scb[0].acc + 1, scb[0].lat);
      end
      if (prev_ov && !prev_rdy) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_outputs", {result, result_hi, flag_z, flag_c, flag_v, flag_n}, {s_r, s_hi, s_f});
      end
      if (out_valid && out_ready && scb.size() > 0) begin
        e = scb.pop_front();
        chk("result", result, e.r[W-1:0]);
        chk("result_hi", result_hi, e.hi[W-1:0]);
        chk("flags_zcvn", {flag_z, flag_c, flag_v, flag_n}, {e.z, e.c, e.v, e.n});
        expect_ready = 1;
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
      s_r  = result; s_hi = result_hi;
      s_f  = {flag_z, flag_c, flag_v, flag_n};
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);

    // Directed cases.
    send(3'd0, 8'hF0, 8'h20);
    send(3'd1, 8'h80, 8'h01);
    send(3'd1, 8'h05, 8'h07);
    send(3'd1, 8'h33, 8'h33);
    send(3'd7, 8'hFF, 8'hFF);
    send(3'd5, 8'h81, 8'h01);
    send(3'd6, 8'h81, 8'h01);
    send(3'd5, 8'h81, 8'h00);
    send(3'd7, 8'h00, 8'h5A);
    hold = 6;
    send(3'd0, 8'h7F, 8'h01);

    // Reset on the 4th BUSY cycle of a MUL.
    in_valid = 1'b1; op = 3'd7; data1 = 8'hAB; data2 = 8'hCD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mul_busy_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);
    send(3'd0, 8'h01, 8'h01);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational adder ALU.
- WIDTH-bit operands; eight operations; status flags; iterative multiplier.
- Valid/ready handshake on both sides, one operation in flight.
- Sits between the operand/decode stage and the writeback register in the processor datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept (high only in IDLE)
op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR(logical), 7 MUL(unsigned)
data1  input  WIDTH  operand A
data2  input  WIDTH  operand B; shifts use data2[SHW-1:0]
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
result  output  WIDTH  result (MUL: low half)
result_hi  output  WIDTH  MUL high half; 0 for all other ops
flag_z  output  1  zero
flag_c  output  1  carry/borrow/shift-out/MUL-high-nonzero
flag_v  output  1  signed overflow
flag_n  output  1  result[WIDTH-1]

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; result, result_hi, all flags, out_valid = 0; MUL counter 0; in_ready = 1 once rst_n deasserts. Reset during BUSY/DONE aborts; no partial result visible.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready: latch op, data1, data2.
  - op!=MUL -> compute, register outputs, go DONE. out_valid high on the cycle after accept (latency 1).
  - op==MUL -> go BUSY; counter = WIDTH.
- BUSY: one shift-add step per cycle, LSB-first over data2. Counter decrements. When the last step completes, register the 2*WIDTH product and go DONE. out_valid first high WIDTH+1 cycles after accept. in_ready=0.
- DONE: out_valid=1. result and flags held stable until out_ready. out_valid&&out_ready -> IDLE. No new accept in the same cycle; next accept is possible one cycle later. Back-to-back throughput is therefore 1 op per 2 cycles.
- Arithmetic is WIDTH bits, with wrap-around modulo 2^WIDTH.
  - ADD: c = carry-out. v = operands have the same sign and the result sign differs.
  - SUB: A-B. c = borrow (A<B unsigned). v = operand signs differ and the result sign differs from A.
  - AND/OR/XOR: c=0, v=0.
  - SHL: zero-fill. c = last bit shifted out (bit WIDTH-sh of A); sh=0 gives c=0. v=0.
  - SHR: zero-fill. c = bit sh-1 of A; sh=0 gives c=0. v=0.
  - MUL: unsigned, {result_hi,result} = A*B. c = |result_hi. v=0.
- flag_z: result==0; for MUL, the full 2*WIDTH product ==0. flag_n = result[WIDTH-1] for all ops.
- in_valid while not in IDLE: ignored, and the operands are not latched.
- Outputs change only on clk edges or reset; no combinational path from inputs to outputs except in_ready (derived from state only).

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_MUL), state encodings (ST_IDLE, ST_BUSY, ST_DONE), flag bit indices.
- Sub-module alu_mul_iter: WIDTH-parametrised shift-add engine.
  - Ports: clk, rst_n, start, a, b, busy, done, product[2*WIDTH-1:0].
  - alu_seq owns the FSM, the single-cycle ops and the handshake.

Test Plan:
- ADD 8'hF0+8'h20 -> result 8'h10, c=1, z=0, v=0, n=0; out_valid exactly 1 cycle after accept.
- SUB 8'h80-8'h01 -> 8'h7F, v=1, c=0; SUB 8'h05-8'h07 -> 8'hFE, c=1, n=1; SUB 8'h33-8'h33 -> 8'h00, z=1.
- MUL 8'hFF*8'hFF -> result 8'h01, result_hi 8'hFE, c=1, z=0; out_valid 9 cycles after accept; in_ready=0 throughout; in_valid pulses during BUSY are ignored.
- SHL 8'h81 by 1 -> 8'h02, c=1; SHR 8'h81 by 1 -> 8'h40, c=1; SHL 8'h81 by 0 -> 8'h81, c=0.
- Backpressure: after an ADD, hold out_ready=0 for 5 cycles -> result/flags stable and out_valid=1; IDLE reached on the handshake cycle; in_ready=1 the next cycle.
- Assert rst_n=0 on the 4th BUSY cycle of a MUL -> all outputs 0 immediately (asynchronously); after release, in_ready=1 and a fresh ADD 1+1 -> 8'h02.
